// File: rtl/therm_pkg.sv
// Shared constants, types and helpers for the flash ADC thermometer encoder.
package therm_pkg;

   localparam int B_W = 4;
   localparam int N_Y = 2**B_W - 1;

   typedef logic [B_W-1:0] code_t;
   typedef logic [N_Y-1:0] therm_t;

   function automatic logic maj3(input logic a, input logic m, input logic c);
      return (a & m) | (a & c) | (m & c);
   endfunction

endpackage

// File: rtl/therm_popcount.sv
// Combinational population count: N_Y = 2**B_W-1 input bits to a B_W-bit count.
module therm_popcount
   import therm_pkg::*;
#(
   parameter  int B_W_P = B_W,
   localparam int N_Y_P = 2**B_W_P - 1
)(
   input  logic [N_Y_P-1:0] y,
   output logic [B_W_P-1:0] cnt
);

   // The maximum count N_Y_P fits B_W_P bits exactly, so the sum never wraps.
   always_comb begin
      // NOTE: assign a default before the loop so no path leaves cnt unassigned (no latch).
      cnt = '0;
      for (int i = 0; i < N_Y_P; i++) begin
         cnt = cnt + B_W_P'(y[i]);
      end
   end

endmodule

// File: rtl/therm_encoder.sv
// Thermometer-to-binary encoder with one output register.
// Optional bubble correction is enabled by defining THERM_BUBBLE_CORRECT_EN.
module therm_encoder
   import therm_pkg::*;
#(
   parameter  int B_W_P = B_W,
   localparam int N_Y_P = 2**B_W_P - 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_Y_P-1:0] Y,
   output logic [B_W_P-1:0] b
);

   logic [N_Y_P-1:0] yc;
   logic [B_W_P-1:0] cnt;

`ifdef THERM_BUBBLE_CORRECT_EN
   // Pad with 0 below the LSB and 1 above the MSB so valid codes pass unchanged.
   logic [N_Y_P+1:0] y_ext;
   assign y_ext = {1'b1, Y, 1'b0};

   always_comb begin
      yc = '0;
      for (int i = 0; i < N_Y_P; i++) begin
         yc[i] = maj3(y_ext[i], y_ext[i+1], y_ext[i+2]);
      end
   end
`else
   assign yc = Y;
`endif

   therm_popcount #(.B_W_P(B_W_P)) u_popcount (
      .y   (yc),
      .cnt (cnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignment to avoid ordering races.
      if (!rst) b <= '0;
      else      b <= cnt;
   end

endmodule

// File: tb/tb_therm_encoder.sv
// Directed self-checking bench for therm_encoder; expectations follow THERM_BUBBLE_CORRECT_EN.
module tb_therm_encoder;
   import therm_pkg::*;

   logic   clk = 1'b0;
   logic   rst;
   therm_t Y;
   code_t  b;

   int checks = 0;
   int errors = 0;

   therm_encoder dut (
      .clk (clk),
      .rst (rst),
      .Y   (Y),
      .b   (b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input code_t got, input code_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      therm_t vec;
      code_t  exp_bubble, exp_lo, exp_hi;

`ifdef THERM_BUBBLE_CORRECT_EN
      exp_bubble = 4'd10;
      exp_lo     = 4'd0;
      exp_hi     = 4'd15;
`else
      exp_bubble = 4'd9;
      exp_lo     = 4'd1;
      exp_hi     = 4'd14;
`endif

      // Reset held with all-ones input and clock running
      rst = 1'b0;
      Y   = 15'h7FFF;
      #1;
      check("reset_initial", b, 4'd0);
      repeat (3) step();
      check("reset_held", b, 4'd0);
      rst = 1'b1;
      #2;
      check("reset_release_no_edge", b, 4'd0);
      step();
      check("reset_release_first_edge", b, 4'd15);

      // Full sweep, one thermometer code per cycle
      for (int k = 0; k < 16; k++) begin
         vec = 15'h7FFF;
         vec = vec << k;
         Y = vec;
         step();
         check($sformatf("sweep_%0d", k), b, code_t'(15 - k));
      end

      // Latency: input change after an edge is invisible until the next edge
      Y = 15'h0000;
      step();
      check("latency_zero", b, 4'd0);
      Y = 15'h7F80;
      #3;
      check("latency_hold", b, 4'd0);
      step();
      check("latency_update", b, 4'd8);

      // Asynchronous reset between edges
      Y = 15'h7FF8;
      step();
      check("async_pre", b, 4'd12);
      #2;
      rst = 1'b0;
      #1;
      check("async_clear", b, 4'd0);
      step();
      check("async_held", b, 4'd0);
      rst = 1'b1;
      step();
      check("async_recover", b, 4'd12);

      // Bubble and boundary codes
      Y = 15'b111111101100000;
      step();
      check("bubble", b, exp_bubble);
      Y = 15'h0001;
      step();
      check("boundary_lsb_only", b, exp_lo);
      Y = 15'h3FFF;
      step();
      check("boundary_msb_zero", b, exp_hi);
      Y = 15'h7FE0;
      step();
      check("valid_10", b, 4'd10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
